count_share_ctrl: RTL and testbench
===================================

// Module: count_share_ctrl
// PURPOSE
//   Sequencer/arbiter that shares the calculator's single 4-bit count unit between two
//   requesters (A, B). Arbitrates round-robin and clears the count unit for the winner.
//   Enables it for exactly the requested number of ticks, then signals completion.
//   Sits between the calculator control logic and the count unit (which increments
//   cnt_val on each clk rising edge while cnt_en=1 and zeroes it when cnt_clr=1).
// PARAMETERS
//   WIDTH       4   width of run lengths and of the count unit value
//   GAP_CYCLES  1   idle cycles inserted after each run before re-arbitration (0..7)
// PORTS
//   clk      in   1      clock, all state updates on rising edge
//   rst_n    in   1      reset, asynchronous, active-low
//   req_a    in   1      requester A wants a run; hold high until done_a
//   len_a    in   WIDTH  run length for A, sampled on the grant edge
//   gnt_a    out  1      A owns the count unit
//   done_a   out  1      one-cycle pulse: A's run complete
//   req_b    in   1      as req_a, requester B
//   len_b    in   WIDTH  as len_a, requester B
//   gnt_b    out  1      as gnt_a, requester B
//   done_b   out  1      as done_a, requester B
//   cnt_clr  out  1      clear strobe to the count unit
//   cnt_en   out  1      count enable to the count unit
//   cnt_val  in   WIDTH  current count unit value
//   busy     out  1      high in any state other than IDLE
//   err      out  1      one-cycle pulse with done_x if cnt_val != latched length
// BEHAVIOUR
//   - Reset (rst_n=0, async): state IDLE, all outputs 0, priority pointer = A, len_q = 0.
//   - States: IDLE, CLEAR, RUN, DONE, GAP; all outputs decode from registered state/owner.
//   - IDLE: if any req, pick winner (both high: pointer side; one high: that side).
//     Latch owner, len_q <= len_winner, ticks <= 0. Next state CLEAR. No req: stay IDLE.
//   - CLEAR: gnt_owner=1, cnt_clr=1, cnt_en=0, one cycle.
//     Next RUN if len_q != 0, else DONE.
//   - RUN: gnt_owner=1, cnt_en=1, ticks increments each cycle.
//     After len_q cycles, go to DONE, so cnt_en is high for exactly len_q cycles.
//   - DONE: gnt_owner=1, done_owner=1, cnt_en=0, one cycle.
//     err=1 this cycle iff cnt_val != len_q. Pointer <= other side.
//     Next GAP if GAP_CYCLES>0, else IDLE.
//   - GAP: all gnt/done/cnt_* low, busy=1, for GAP_CYCLES cycles, then IDLE.
//   - Latency: req sampled high at edge k -> gnt and cnt_clr from edge k+1.
//     RUN spans edges k+2..k+1+len. done pulse from edge k+2+len (len=0: from k+2).
//   - Abort: owner's req low while in CLEAR or RUN.
//     Next edge: cnt_en=0, no done, no err, pointer <= other side.
//     Next state GAP (or IDLE if GAP_CYCLES=0). req low during DONE is ignored.
//   - Non-owner req and len are ignored while busy. gnt_a and gnt_b are never high together.
//   - len_q max 2^WIDTH-1, so the count unit never wraps within a run.
//     Length changes after the grant edge have no effect on the current run.
//   - Reset mid-run: immediate return to reset values. The count unit value is not
//     cleared by this block until the next CLEAR.
// TESTING
//   1. req_a=1, len_a=5 from IDLE -> gnt_a from edge 1, cnt_clr edges 1-2,
//      cnt_en 5 cycles, done_a at edge 7, err=0 against a model count unit.
//   2. req_a=req_b=1 held, len 3 each, GAP_CYCLES=1 -> grant order A,B,A,B.
//      Never overlapping; 1-cycle gap between runs.
//   3. req_b=1, len_b=0 -> CLEAR then DONE, cnt_en never high, done_b 2 edges after grant,
//      err=0 (cnt_val=0).
//   4. req_a=1, len_a=9; drop req_a after 2 RUN cycles, req_b=1 -> cnt_en low next edge.
//      No done_a; gnt_b after the gap.
//   5. Model count unit stuck at 2, len_a=4 -> err=1 coincident with done_a, for one cycle.
//   6. Assert rst_n=0 mid-RUN -> all outputs 0 without waiting for clk.
//      Release with req_a=req_b=1 -> A granted first.

Source files
------------

// File: rtl/count_share_ctrl.sv
// count_share_ctrl
// Round-robin sequencer that lends the single count unit to requester A or B.
// Each run clears the count unit, enables it for the latched number of ticks,
// reports done (and err if the unit disagrees), then idles for GAP_CYCLES.
// Outputs are registered, so they trail the internal state by one edge.

module count_share_ctrl #(
   parameter int WIDTH      = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic [WIDTH-1:0] len_a,
   output logic             gnt_a,
   output logic             done_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] len_b,
   output logic             gnt_b,
   output logic             done_b,
   output logic             cnt_clr,
   output logic             cnt_en,
   input  logic [WIDTH-1:0] cnt_val,
   output logic             busy,
   output logic             err
);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DONE, GAP} state_t;

   localparam logic [2:0] GAP_LAST = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;
   localparam logic       HAS_GAP  = (GAP_CYCLES > 0);

   state_t           state;
   state_t           post_state;
   logic             owner;
   logic             ptr;
   logic [WIDTH-1:0] len_q;
   logic [WIDTH-1:0] ticks;
   logic [2:0]       gap_cnt;
   logic             owner_req;
   logic             pick_b;
   logic             abort;

   // Owner is 0 for A and 1 for B; the pointer only breaks ties when both request.
   assign owner_req = owner ? req_b : req_a;
   assign pick_b    = (req_a && req_b) ? ptr : req_b;
   assign abort     = ((state == CLEAR) || (state == RUN)) && !owner_req;

   // Where a finished or abandoned run goes next: the idle gap if there is one.
   always_comb begin
      post_state = IDLE;
      if (HAS_GAP) post_state = GAP;
   end

   // The count unit's last increment lands on the same edge that raises done,
   // so the length check is made against the live value during the done cycle.
   assign err = (done_a | done_b) & (cnt_val != len_q);

   // Sequencer: state walk plus registered decode of the state being left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         owner   <= 1'b0;
         ptr     <= 1'b0;
         len_q   <= '0;
         ticks   <= '0;
         gap_cnt <= '0;
         gnt_a   <= 1'b0;
         gnt_b   <= 1'b0;
         done_a  <= 1'b0;
         done_b  <= 1'b0;
         cnt_clr <= 1'b0;
         cnt_en  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         gnt_a   <= 1'b0;
         gnt_b   <= 1'b0;
         done_a  <= 1'b0;
         done_b  <= 1'b0;
         cnt_clr <= 1'b0;
         cnt_en  <= 1'b0;
         busy    <= 1'b1;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (req_a || req_b) begin
                  owner <= pick_b;
                  len_q <= pick_b ? len_b : len_a;
                  ticks <= '0;
                  state <= CLEAR;
               end
            end
            CLEAR: begin
               if (abort) begin
                  ptr     <= ~owner;
                  gap_cnt <= '0;
                  busy    <= HAS_GAP;
                  state   <= post_state;
               end else begin
                  gnt_a   <= ~owner;
                  gnt_b   <= owner;
                  cnt_clr <= 1'b1;
                  state   <= (len_q != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (abort) begin
                  ptr     <= ~owner;
                  gap_cnt <= '0;
                  busy    <= HAS_GAP;
                  state   <= post_state;
               end else begin
                  gnt_a  <= ~owner;
                  gnt_b  <= owner;
                  cnt_en <= 1'b1;
                  ticks  <= ticks + 1'b1;
                  if (ticks == len_q - 1'b1) state <= DONE;
               end
            end
            DONE: begin
               gnt_a   <= ~owner;
               gnt_b   <= owner;
               done_a  <= ~owner;
               done_b  <= owner;
               ptr     <= ~owner;
               gap_cnt <= '0;
               state   <= post_state;
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) state <= IDLE;
               else gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_count_share_ctrl.sv
// tb_count_share_ctrl
// Drives two requesters against count_share_ctrl and a model count unit, and
// compares every cycle with a run-timeline reference model.

module tb_count_share_ctrl;

   localparam int GAP = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_a, req_b;
   logic [3:0] len_a, len_b;
   logic       gnt_a, gnt_b, done_a, done_b, cnt_clr, cnt_en, busy, err;
   logic [3:0] cnt_val;
   logic       stuck;
   logic [7:0] dut_vec;

   int checks = 0;
   int errors = 0;

   // Reference model: one run described by owner, length, first grant cycle,
   // and the first cycle at which the arbiter may look at requests again.
   int t, m_start, m_len, m_free, m_abort_t;
   bit m_active, m_aborted, m_owner, m_ptr;

   count_share_ctrl #(.WIDTH(4), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .len_a(len_a), .gnt_a(gnt_a), .done_a(done_a),
      .req_b(req_b), .len_b(len_b), .gnt_b(gnt_b), .done_b(done_b),
      .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_val(cnt_val),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   assign dut_vec = {gnt_a, gnt_b, done_a, done_b, cnt_clr, cnt_en, busy, err};

   // Model count unit, optionally stuck at 2 to provoke the length check.
   always_ff @(posedge clk) begin
      if (stuck) cnt_val <= 4'd2;
      else if (cnt_clr) cnt_val <= 4'd0;
      else if (cnt_en) cnt_val <= cnt_val + 4'd1;
   end

   task automatic model_reset();
      t = 0; m_free = 0; m_start = 0; m_len = 0; m_abort_t = 0;
      m_active = 0; m_aborted = 0; m_owner = 0; m_ptr = 0;
   endtask

   // Advance the model across one rising edge using the inputs present at it.
   task automatic model_edge();
      t++;
      if (m_active && !m_aborted && t >= m_start && t <= m_start + m_len &&
          !(m_owner ? req_b : req_a)) begin
         m_aborted = 1; m_abort_t = t; m_free = t + GAP + 1;
      end else if (t >= m_free && (req_a || req_b)) begin
         m_owner   = (req_a && req_b) ? m_ptr : req_b;
         m_len     = m_owner ? int'(len_b) : int'(len_a);
         m_ptr     = !m_owner;
         m_active  = 1; m_aborted = 0;
         m_start   = t + 1;
         m_free    = m_start + m_len + 2 + GAP;
      end
   endtask

   // Expected outputs after edge t, from the run's phase within its timeline.
   function automatic logic [7:0] exp_vec();
      logic ga, gb, da, db, clr, en, bz, er;
      int p;
      {ga, gb, da, db, clr, en, bz, er} = 8'h00;
      if (m_active && t >= m_start) begin
         p = t - m_start;
         if (m_aborted && t >= m_abort_t) begin
            bz = (GAP > 0) && (t <= m_abort_t + GAP);
         end else begin
            ga  = (p <= m_len + 1) && !m_owner;
            gb  = (p <= m_len + 1) && m_owner;
            clr = (p == 0);
            en  = (p >= 1) && (p <= m_len);
            da  = (p == m_len + 1) && !m_owner;
            db  = (p == m_len + 1) && m_owner;
            bz  = (p <= m_len + 1 + GAP);
            er  = (p == m_len + 1) && stuck && (m_len != 2);
         end
      end
      return {ga, gb, da, db, clr, en, bz, er};
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_a = 0; req_b = 0;
      @(negedge clk); rst_n = 0;
      @(negedge clk); rst_n = 1; model_reset();
   endtask

   task automatic test_reset();
      #1 rst_n = 0;
      #1;
      checks++;
      if (dut_vec !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_async got %b expected %b", dut_vec, 8'h00);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (dut_vec !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_hold got %b expected %b", dut_vec, 8'h00);
      end
      rst_n = 1; model_reset();
   endtask

   task automatic test_single_a();
      int g = -1, d = -1, en_n = 0;
      req_a = 1; len_a = 4'd5;
      for (int i = 0; i < 14; i++) begin
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL single_a t=%0d got %b expected %b", t, dut_vec, exp_vec());
         end
         if (gnt_a && g < 0) g = t;
         if (cnt_en) en_n++;
         if (done_a) begin d = t; req_a = 0; end
      end
      checks++;
      if (en_n !== 5) begin
         errors++; $display("[TB] FAIL single_a_en_cycles got %0d expected %0d", en_n, 5);
      end
      checks++;
      if (d - g !== 6) begin
         errors++; $display("[TB] FAIL single_a_done_latency got %0d expected %0d", d - g, 6);
      end
   endtask

   task automatic test_alternate();
      bit order[$];
      int overlap = 0;
      logic pa = 0, pb = 0;
      do_reset();
      req_a = 1; req_b = 1; len_a = 4'd3; len_b = 4'd3;
      for (int i = 0; i < 40; i++) begin
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL alternate t=%0d got %b expected %b", t, dut_vec, exp_vec());
         end
         if (gnt_a && gnt_b) overlap++;
         if (gnt_a && !pa) order.push_back(1'b0);
         if (gnt_b && !pb) order.push_back(1'b1);
         pa = gnt_a; pb = gnt_b;
         if (order.size() >= 4) begin
            if (!gnt_a) req_a = 0;
            if (done_b) req_b = 0;
         end
      end
      checks++;
      if (order.size() < 4 || order[0] !== 1'b0 || order[1] !== 1'b1 ||
          order[2] !== 1'b0 || order[3] !== 1'b1) begin
         errors++; $display("[TB] FAIL alternate_order got %p expected A,B,A,B (0,1,0,1)", order);
      end
      checks++;
      if (overlap !== 0) begin
         errors++; $display("[TB] FAIL alternate_overlap got %0d expected 0", overlap);
      end
   endtask

   task automatic test_zero_len();
      int en_n = 0, g = -1, d = -1;
      req_b = 1; len_b = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL zero_len t=%0d got %b expected %b", t, dut_vec, exp_vec());
         end
         if (cnt_en) en_n++;
         if (gnt_b && g < 0) g = t;
         if (done_b) begin d = t; req_b = 0; end
      end
      checks++;
      if (en_n !== 0 || d - g !== 1) begin
         errors++; $display("[TB] FAIL zero_len_shape got en=%0d lat=%0d expected en=0 lat=1", en_n, d - g);
      end
   endtask

   task automatic test_abort();
      int n = 0;
      bit saw_done = 0, saw_b = 0;
      req_a = 1; len_a = 4'd9; req_b = 0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL abort t=%0d got %b expected %b", t, dut_vec, exp_vec());
         end
         if (cnt_en && gnt_a) n++;
         if (done_a) saw_done = 1;
         if (gnt_b) saw_b = 1;
         if (done_b) req_b = 0;
         if (n == 2 && req_a) begin req_a = 0; req_b = 1; len_b = 4'd3; end
      end
      checks++;
      if (saw_done !== 1'b0 || saw_b !== 1'b1 || n !== 2) begin
         errors++; $display("[TB] FAIL abort_outcome got done_a=%0d gnt_b=%0d en=%0d expected 0 1 2", saw_done, saw_b, n);
      end
   endtask

   task automatic test_err_stuck();
      int err_n = 0;
      bit err_with_done = 0;
      stuck = 1; req_a = 1; len_a = 4'd4;
      for (int i = 0; i < 14; i++) begin
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL err_stuck t=%0d got %b expected %b", t, dut_vec, exp_vec());
         end
         if (err) err_n++;
         if (err && done_a) err_with_done = 1;
         if (done_a) req_a = 0;
      end
      stuck = 0;
      checks++;
      if (err_n !== 1 || err_with_done !== 1'b1) begin
         errors++; $display("[TB] FAIL err_pulse got count=%0d with_done=%0d expected 1 1", err_n, err_with_done);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 430; i++) begin
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL random t=%0d got %b expected %b", t, dut_vec, exp_vec());
         end
         if (i >= 400) begin
            req_a = 0; req_b = 0;
         end else begin
            if (!req_a) begin
               if ($urandom_range(0, 2) == 0) begin req_a = 1; len_a = 4'($urandom_range(0, 15)); end
            end else if (done_a) req_a = 0;
            else if (gnt_a && $urandom_range(0, 19) == 0) req_a = 0;
            else if ($urandom_range(0, 3) == 0) len_a = 4'($urandom_range(0, 15));
            if (!req_b) begin
               if ($urandom_range(0, 2) == 0) begin req_b = 1; len_b = 4'($urandom_range(0, 15)); end
            end else if (done_b) req_b = 0;
            else if (gnt_b && $urandom_range(0, 19) == 0) req_b = 0;
            else if ($urandom_range(0, 3) == 0) len_b = 4'($urandom_range(0, 15));
         end
      end
   endtask

   task automatic test_reset_midrun();
      int n = 0, first = -1;
      req_a = 0; req_b = 1; len_b = 4'd10;
      for (int i = 0; i < 30 && n < 3; i++) begin
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL midrun t=%0d got %b expected %b", t, dut_vec, exp_vec());
         end
         if (cnt_en) n++;
      end
      checks++;
      if (n !== 3) begin
         errors++; $display("[TB] FAIL midrun_reach_run got %0d expected 3", n);
      end
      #2 rst_n = 0;
      req_a = 1; req_b = 1; len_a = 4'd3; len_b = 4'd3;
      #1;
      checks++;
      if (dut_vec !== 8'h00) begin
         errors++; $display("[TB] FAIL midrun_async_clear got %b expected %b", dut_vec, 8'h00);
      end
      @(negedge clk); rst_n = 1; model_reset();
      for (int i = 0; i < 16; i++) begin
         cycle();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL post_reset t=%0d got %b expected %b", t, dut_vec, exp_vec());
         end
         if (first < 0 && gnt_a) first = 0;
         if (first < 0 && gnt_b) first = 1;
         if (done_a) req_a = 0;
         if (done_b) req_b = 0;
      end
      checks++;
      if (first !== 0) begin
         errors++; $display("[TB] FAIL post_reset_first_grant got %0d expected 0 (A)", first);
      end
   endtask

   initial begin
      req_a = 0; req_b = 0; len_a = 0; len_b = 0; stuck = 0;
      model_reset();
      test_reset();
      test_single_a();
      test_alternate();
      test_zero_len();
      test_abort();
      test_err_stuck();
      test_random();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
